// File: rtl/prog_loader_if.sv
// Byte-stream and memory-port bundle between the program loader and its surroundings.
// The loader side takes the master modport: it drives the memory port and consumes the stream.
interface prog_loader_if #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 8
);
   logic                  s_valid;
   logic [DATA_WIDTH-1:0] s_data;
   logic                  s_ready;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_din;
   logic [DATA_WIDTH-1:0] mem_dout;

   modport master (
      input  s_valid, s_data, mem_dout,
      output s_ready, mem_we, mem_addr, mem_din
   );

   modport slave (
      output s_valid, s_data, mem_dout,
      input  s_ready, mem_we, mem_addr, mem_din
   );
endinterface

// File: rtl/prog_loader.sv
// Program loader: streams an image into memory, reads it back against a running checksum,
// and keeps the core in reset until the image has verified.
module prog_loader #(
   parameter int ADDR_WIDTH    = 16,
   parameter int DATA_WIDTH    = 8,
   parameter int DEPTH         = 32,
   parameter bit HOLD_AT_RESET = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] load_base,
   input  logic [ADDR_WIDTH-1:0] load_len,
   prog_loader_if.master         bus,
   output logic                  bus_own,
   output logic                  cpu_hold,
   output logic                  done,
   output logic                  error,
   output logic [1:0]            err_code,
   output logic [DATA_WIDTH-1:0] checksum
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_VERIFY,
      ST_CHECK,
      ST_DONE,
      ST_ERROR
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] ONE       = ADDR_WIDTH'(1);
   localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH+1)'(DEPTH);

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] base_q, base_d;
   logic [ADDR_WIDTH-1:0] len_q, len_d;
   logic [ADDR_WIDTH-1:0] idx_q, idx_d;
   logic [DATA_WIDTH-1:0] load_sum_q, load_sum_d;
   logic [DATA_WIDTH-1:0] rd_sum_q, rd_sum_d;
   logic                  rd_en_q, rd_en_d;
   logic                  rd_dv_q, rd_dv_d;
   logic                  mem_we_q, mem_we_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_WIDTH-1:0] mem_din_q, mem_din_d;
   logic                  bus_own_q, bus_own_d;
   logic                  cpu_hold_q, cpu_hold_d;
   logic                  done_q, done_d;
   logic                  error_q, error_d;
   logic [1:0]            err_code_q, err_code_d;
   logic [DATA_WIDTH-1:0] checksum_q, checksum_d;

   logic [ADDR_WIDTH:0]   end_addr;
   logic                  range_bad;
   logic                  start_ok;
   logic                  s_ready;
   logic                  handshake;
   logic                  last_idx;
   logic [DATA_WIDTH-1:0] final_sum;
   logic                  verify_ok;

   // End address is formed one bit wider so an image running past the top cannot wrap into range.
   assign end_addr  = {1'b0, load_base} + {1'b0, load_len};
   assign range_bad = end_addr > DEPTH_EXT;
   assign start_ok  = start && (state_q == ST_IDLE || state_q == ST_DONE || state_q == ST_ERROR);
   assign s_ready   = (state_q == ST_LOAD) && (idx_q < len_q);
   assign handshake = bus.s_valid && s_ready;
   assign last_idx  = (idx_q == len_q - ONE);
   assign final_sum = rd_sum_q + (rd_dv_q ? bus.mem_dout : '0);
   assign verify_ok = (final_sum == load_sum_q);

   always_ff @(posedge clk) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // CHECK waits until the last read address has retired so final_sum includes the last byte.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE, ST_DONE, ST_ERROR: begin
            if (start) begin
               if (range_bad)            state_d = ST_ERROR;
               else if (load_len == '0)  state_d = ST_DONE;
               else                      state_d = ST_LOAD;
            end
         end
         ST_LOAD:   if (handshake && last_idx) state_d = ST_VERIFY;
         ST_VERIFY: if (last_idx)              state_d = ST_CHECK;
         ST_CHECK:  if (!rd_en_q)              state_d = verify_ok ? ST_DONE : ST_ERROR;
         default:                              state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      base_d     = base_q;
      len_d      = len_q;
      idx_d      = idx_q;
      load_sum_d = load_sum_q;
      rd_sum_d   = rd_dv_q ? final_sum : rd_sum_q;
      rd_en_d    = 1'b0;
      rd_dv_d    = rd_en_q;
      mem_we_d   = 1'b0;
      mem_addr_d = mem_addr_q;
      mem_din_d  = mem_din_q;
      bus_own_d  = bus_own_q;
      cpu_hold_d = cpu_hold_q;
      done_d     = done_q;
      error_d    = error_q;
      err_code_d = err_code_q;
      checksum_d = checksum_q;

      if (start_ok) begin
         done_d     = 1'b0;
         error_d    = 1'b0;
         err_code_d = 2'b00;
         checksum_d = '0;
         if (range_bad) begin
            error_d    = 1'b1;
            err_code_d = 2'b01;
         end else if (load_len == '0) begin
            done_d     = 1'b1;
            cpu_hold_d = 1'b0;
         end else begin
            base_d     = load_base;
            len_d      = load_len;
            idx_d      = '0;
            load_sum_d = '0;
            rd_sum_d   = '0;
            bus_own_d  = 1'b1;
            cpu_hold_d = 1'b1;
         end
      end

      case (state_q)
         ST_LOAD: begin
            if (handshake) begin
               mem_we_d   = 1'b1;
               mem_addr_d = base_q + idx_q;
               mem_din_d  = bus.s_data;
               load_sum_d = load_sum_q + bus.s_data;
               idx_d      = last_idx ? '0 : idx_q + ONE;
            end
         end
         ST_VERIFY: begin
            mem_addr_d = base_q + idx_q;
            rd_en_d    = 1'b1;
            idx_d      = idx_q + ONE;
         end
         ST_CHECK: begin
            if (!rd_en_q) begin
               bus_own_d  = 1'b0;
               checksum_d = load_sum_q;
               if (verify_ok) begin
                  done_d     = 1'b1;
                  cpu_hold_d = 1'b0;
               end else begin
                  error_d    = 1'b1;
                  err_code_d = 2'b10;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         base_q     <= '0;
         len_q      <= '0;
         idx_q      <= '0;
         load_sum_q <= '0;
         rd_sum_q   <= '0;
         rd_en_q    <= 1'b0;
         rd_dv_q    <= 1'b0;
         mem_we_q   <= 1'b0;
         mem_addr_q <= '0;
         mem_din_q  <= '0;
         bus_own_q  <= 1'b0;
         cpu_hold_q <= HOLD_AT_RESET;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
         err_code_q <= 2'b00;
         checksum_q <= '0;
      end else begin
         base_q     <= base_d;
         len_q      <= len_d;
         idx_q      <= idx_d;
         load_sum_q <= load_sum_d;
         rd_sum_q   <= rd_sum_d;
         rd_en_q    <= rd_en_d;
         rd_dv_q    <= rd_dv_d;
         mem_we_q   <= mem_we_d;
         mem_addr_q <= mem_addr_d;
         mem_din_q  <= mem_din_d;
         bus_own_q  <= bus_own_d;
         cpu_hold_q <= cpu_hold_d;
         done_q     <= done_d;
         error_q    <= error_d;
         err_code_q <= err_code_d;
         checksum_q <= checksum_d;
      end
   end

   assign bus.s_ready  = s_ready;
   assign bus.mem_we   = mem_we_q;
   assign bus.mem_addr = mem_addr_q;
   assign bus.mem_din  = mem_din_q;
   assign bus_own      = bus_own_q;
   assign cpu_hold     = cpu_hold_q;
   assign done         = done_q;
   assign error        = error_q;
   assign err_code     = err_code_q;
   assign checksum     = checksum_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: a small synchronous memory with a fetcher-side mux,
// a stream driver, and a write monitor, with hand-computed expectations.
module tb_prog_loader;

   localparam int AW    = 16;
   localparam int DW    = 8;
   localparam int DEPTH = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [AW-1:0] load_base;
   logic [AW-1:0] load_len;
   logic          bus_own;
   logic          cpu_hold;
   logic          done;
   logic          error;
   logic [1:0]    err_code;
   logic [DW-1:0] checksum;

   prog_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_if ();

   prog_loader #(
      .ADDR_WIDTH   (AW),
      .DATA_WIDTH   (DW),
      .DEPTH        (DEPTH),
      .HOLD_AT_RESET(1'b1)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .load_base(load_base),
      .load_len (load_len),
      .bus      (bus_if),
      .bus_own  (bus_own),
      .cpu_hold (cpu_hold),
      .done     (done),
      .error    (error),
      .err_code (err_code),
      .checksum (checksum)
   );

   always #5 clk = ~clk;

   // Memory with one-cycle read latency; the loader owns the port only while bus_own is high.
   logic [DW-1:0] mem [0:DEPTH-1];
   logic [AW-1:0] fetch_addr;
   logic [AW-1:0] port_addr;
   logic          corrupt;
   logic          clear_mem;

   assign port_addr = bus_own ? bus_if.mem_addr : fetch_addr;

   always @(posedge clk) begin
      if (clear_mem) begin
         for (int i = 0; i < DEPTH; i++) mem[5'(i)] <= 8'h00;
      end else if (bus_own && bus_if.mem_we) begin
         mem[port_addr[4:0]] <= bus_if.mem_din;
      end
      if (corrupt && port_addr == 16'h0011) bus_if.mem_dout <= 8'h05;
      else                                  bus_if.mem_dout <= mem[port_addr[4:0]];
   end

   // mem_we in a cycle must equal the stream handshake of the cycle before it.
   int we_count;
   int we_bad;
   bit own_seen;
   bit hs_last = 1'b0;

   always @(posedge clk) begin
      if (bus_if.mem_we === 1'b1) we_count++;
      if (bus_if.mem_we !== hs_last) we_bad++;
      if (bus_own === 1'b1) own_seen = 1'b1;
      hs_last = bus_if.s_valid && bus_if.s_ready;
   end

   logic [7:0] img [0:3] = '{8'hA9, 8'h04, 8'h85, 8'h02};
   logic       ready_after;
   int         n_cmp = 0;
   int         n_bad = 0;
   int         cyc;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      n_cmp++;
      if (actual !== expected) begin
         n_bad++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   task automatic clearMonitor();
      we_count = 0;
      we_bad   = 0;
      own_seen = 1'b0;
   endtask

   // Pulses start, then streams the image (junk 0xEE once it runs out) until done/error or budget.
   task automatic applyStimulus(input logic [AW-1:0] base, input logic [AW-1:0] len,
                                input int nbytes, input bit stall, input int mid_start_at,
                                output int cycles);
      int ptr;
      bit hs;
      ptr         = 0;
      ready_after = 1'b1;
      start       = 1'b1;
      load_base   = base;
      load_len    = len;
      bus_if.s_valid = 1'b0;
      @(posedge clk); #1;
      start  = 1'b0;
      cycles = 1;
      while (!(done || error) && cycles < 200) begin
         if (mid_start_at != 0 && cycles == mid_start_at) begin
            start     = 1'b1;
            load_base = 16'h0000;
            load_len  = 16'h0008;
         end else begin
            start = 1'b0;
         end
         bus_if.s_valid = !stall || (cycles % 2 == 1);
         bus_if.s_data  = (ptr < nbytes) ? img[ptr] : 8'hEE;
         hs = bus_if.s_valid && bus_if.s_ready;
         @(posedge clk); #1;
         if (hs) begin
            ptr++;
            if (ptr == nbytes) ready_after = bus_if.s_ready;
         end
         cycles++;
      end
      start          = 1'b0;
      bus_if.s_valid = 1'b0;
   endtask

   task automatic pulseClearMem();
      clear_mem = 1'b1;
      @(posedge clk); #1;
      clear_mem = 1'b0;
   endtask

   initial begin
      reset          = 1'b1;
      start          = 1'b0;
      load_base      = '0;
      load_len       = '0;
      bus_if.s_valid = 1'b0;
      bus_if.s_data  = '0;
      fetch_addr     = '0;
      corrupt        = 1'b0;
      clear_mem      = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset     = 1'b0;
      clear_mem = 1'b0;

      checkOutput("rst_done",     32'(done),          32'h0);
      checkOutput("rst_error",    32'(error),         32'h0);
      checkOutput("rst_err_code", 32'(err_code),      32'h0);
      checkOutput("rst_checksum", 32'(checksum),      32'h0);
      checkOutput("rst_bus_own",  32'(bus_own),       32'h0);
      checkOutput("rst_cpu_hold", 32'(cpu_hold),      32'h1);
      checkOutput("rst_mem_we",   32'(bus_if.mem_we), 32'h0);
      checkOutput("rst_s_ready",  32'(bus_if.s_ready),32'h0);

      $display("[TB] clean load, s_valid held high");
      clearMonitor();
      applyStimulus(16'h0010, 16'h0004, 4, 1'b0, 0, cyc);
      checkOutput("t1_cycles",   32'(cyc),      32'd11);
      checkOutput("t1_done",     32'(done),     32'h1);
      checkOutput("t1_error",    32'(error),    32'h0);
      checkOutput("t1_checksum", 32'(checksum), 32'h34);
      checkOutput("t1_cpu_hold", 32'(cpu_hold), 32'h0);
      checkOutput("t1_bus_own",  32'(bus_own),  32'h0);
      checkOutput("t1_we_count", 32'(we_count), 32'd4);
      checkOutput("t1_we_bad",   32'(we_bad),   32'd0);
      checkOutput("t1_s_ready_after_last", 32'(ready_after), 32'h0);
      for (int i = 0; i < 4; i++)
         checkOutput($sformatf("t1_mem_%0h", 16 + i), 32'(mem[5'(16 + i)]), 32'(img[i]));
      fetch_addr = 16'h0010;
      @(posedge clk); #1;
      checkOutput("t1_fetch_10", 32'(bus_if.mem_dout), 32'hA9);

      $display("[TB] load with alternating stalls");
      pulseClearMem();
      clearMonitor();
      applyStimulus(16'h0010, 16'h0004, 4, 1'b1, 0, cyc);
      checkOutput("t2_done",     32'(done),        32'h1);
      checkOutput("t2_checksum", 32'(checksum),    32'h34);
      checkOutput("t2_we_count", 32'(we_count),    32'd4);
      checkOutput("t2_we_bad",   32'(we_bad),      32'd0);
      checkOutput("t2_s_ready_after_last", 32'(ready_after), 32'h0);
      for (int i = 0; i < 4; i++)
         checkOutput($sformatf("t2_mem_%0h", 16 + i), 32'(mem[5'(16 + i)]), 32'(img[i]));

      $display("[TB] range violation");
      clearMonitor();
      applyStimulus(16'h001E, 16'h0004, 4, 1'b0, 0, cyc);
      checkOutput("t3_cycles",   32'(cyc),      32'd1);
      checkOutput("t3_error",    32'(error),    32'h1);
      checkOutput("t3_done",     32'(done),     32'h0);
      checkOutput("t3_err_code", 32'(err_code), 32'h1);
      checkOutput("t3_we_count", 32'(we_count), 32'd0);
      checkOutput("t3_own_seen", 32'(own_seen), 32'h0);

      $display("[TB] corrupted readback at 0x11");
      corrupt = 1'b1;
      clearMonitor();
      applyStimulus(16'h0010, 16'h0004, 4, 1'b0, 0, cyc);
      checkOutput("t4_cycles",   32'(cyc),      32'd11);
      checkOutput("t4_error",    32'(error),    32'h1);
      checkOutput("t4_done",     32'(done),     32'h0);
      checkOutput("t4_err_code", 32'(err_code), 32'h2);
      checkOutput("t4_cpu_hold", 32'(cpu_hold), 32'h1);
      checkOutput("t4_checksum", 32'(checksum), 32'h34);
      checkOutput("t4_bus_own",  32'(bus_own),  32'h0);
      corrupt = 1'b0;
      applyStimulus(16'h0010, 16'h0004, 4, 1'b0, 0, cyc);
      checkOutput("t4_retry_done",     32'(done),     32'h1);
      checkOutput("t4_retry_err_code", 32'(err_code), 32'h0);
      checkOutput("t4_retry_cpu_hold", 32'(cpu_hold), 32'h0);

      $display("[TB] zero length and start during load");
      clearMonitor();
      applyStimulus(16'h0005, 16'h0000, 0, 1'b0, 0, cyc);
      checkOutput("t5_cycles",   32'(cyc),      32'd1);
      checkOutput("t5_done",     32'(done),     32'h1);
      checkOutput("t5_checksum", 32'(checksum), 32'h00);
      checkOutput("t5_we_count", 32'(we_count), 32'd0);
      checkOutput("t5_own_seen", 32'(own_seen), 32'h0);
      clearMonitor();
      applyStimulus(16'h0010, 16'h0004, 4, 1'b0, 3, cyc);
      checkOutput("t5_mid_cycles",   32'(cyc),      32'd11);
      checkOutput("t5_mid_done",     32'(done),     32'h1);
      checkOutput("t5_mid_checksum", 32'(checksum), 32'h34);
      checkOutput("t5_mid_we_count", 32'(we_count), 32'd4);

      $display("[TB] reset after two bytes");
      begin
         int ptr;
         int budget;
         bit hs;
         ptr       = 0;
         budget    = 0;
         start     = 1'b1;
         load_base = 16'h0010;
         load_len  = 16'h0004;
         @(posedge clk); #1;
         start = 1'b0;
         while (ptr < 2 && budget < 50) begin
            bus_if.s_valid = 1'b1;
            bus_if.s_data  = img[ptr];
            hs = bus_if.s_valid && bus_if.s_ready;
            @(posedge clk); #1;
            if (hs) ptr++;
            budget++;
         end
         checkOutput("t6_bytes_before_reset", 32'(ptr), 32'd2);
         bus_if.s_data = img[ptr];
         reset = 1'b1;
         @(posedge clk); #1;
         reset          = 1'b0;
         bus_if.s_valid = 1'b0;
         checkOutput("t6_mem_we",   32'(bus_if.mem_we),  32'h0);
         checkOutput("t6_s_ready",  32'(bus_if.s_ready), 32'h0);
         checkOutput("t6_cpu_hold", 32'(cpu_hold),       32'h1);
         checkOutput("t6_done",     32'(done),           32'h0);
         checkOutput("t6_error",    32'(error),          32'h0);
         checkOutput("t6_bus_own",  32'(bus_own),        32'h0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
